// File: rtl/transport_arb_pkg.sv
// Shared types for the transport arbiter: FSM states, byte type, default stall timeout.
// No logic; imported by the arbiter top and its round-robin selector.
package transport_arb_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_XFER = 1'b1
   } state_t;

   typedef logic [7:0] byte_t;

   localparam int DEF_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after last_idx, wrapping NUM_CH-1 to 0.
// Zero latency; no backpressure, output is one-hot or all zero when nothing requests.
module rr_arbiter #(
   parameter int NUM_CH = 2,
   parameter int IDXW   = $clog2(NUM_CH)
)(
   input  logic [NUM_CH-1:0] req,
   input  logic [IDXW-1:0]   last_idx,
   output logic [NUM_CH-1:0] win
);

   logic found;

   // Walk outward from the slot after the previous owner; the first requester hit wins.
   always_comb begin
      win   = '0;
      found = 1'b0;
      for (int off = 1; off <= NUM_CH; off++) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (!found && req[i] && (i == ((int'(last_idx) + off) % NUM_CH))) begin
               win[i] = 1'b1;
               found  = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/transport_arbiter.sv
// Packet-atomic round-robin mux of NUM_CH byte streams into one TX FIFO; grant registered, data path zero latency.
// WRFULL drops CH_READY of the owner; optional stall abort under TRANSPORT_ARB_TIMEOUT_EN.
module transport_arbiter
   import transport_arb_pkg::*;
#(
   parameter int NUM_CH         = 2,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
)(
   input  logic                  CLK,
   input  logic                  RESETn,
   input  logic [NUM_CH-1:0]     CH_VALID,
   input  logic [8*NUM_CH-1:0]   CH_DATA,
   input  logic [NUM_CH-1:0]     CH_LAST,
   output logic [NUM_CH-1:0]     CH_READY,
   output logic                  WREN,
   output logic [7:0]            WRDATA,
   input  logic                  WRFULL,
   output logic [NUM_CH-1:0]     GRANT,
   output logic                  BUSY,
   output logic                  TIMEOUT_ERR,
   input  logic                  ERR_CLR
);

   localparam int IDXW = $clog2(NUM_CH);

   state_t              state;
   logic [NUM_CH-1:0]   grant_q;
   logic [IDXW-1:0]     last_idx;
   logic [IDXW-1:0]     g_idx;
   logic [NUM_CH-1:0]   win;
   logic                g_valid;
   byte_t               wr_mux;
   logic                accept_last;
   logic                timeout_hit;

   rr_arbiter #(
      .NUM_CH (NUM_CH),
      .IDXW   (IDXW)
   ) u_rr (
      .req      (CH_VALID),
      .last_idx (last_idx),
      .win      (win)
   );

   // Grant is one-hot or zero, so an all-zero grant (idle or reset) yields zero data.
   always_comb begin
      g_idx   = '0;
      g_valid = 1'b0;
      wr_mux  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (grant_q[i]) begin
            g_idx   = IDXW'(i);
            g_valid = CH_VALID[i];
            wr_mux  = byte_t'(CH_DATA[8*i +: 8]);
         end
      end
   end

   assign CH_READY    = grant_q & {NUM_CH{~WRFULL}};
   assign WREN        = |(CH_VALID & CH_READY);
   assign WRDATA      = wr_mux;
   assign accept_last = WREN & (|(CH_LAST & grant_q));
   assign GRANT       = grant_q;
   assign BUSY        = (state == ST_XFER);

`ifdef TRANSPORT_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] stall_cnt;
   logic          err_q;

   // Fires on the cycle the counter would reach TIMEOUT_CYCLES; FIFO-full cycles never count.
   assign timeout_hit = (state == ST_XFER) && !g_valid && !WRFULL &&
                        (stall_cnt == CW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         stall_cnt <= '0;
      end else if ((state != ST_XFER) || WREN || timeout_hit) begin
         stall_cnt <= '0;
      end else if (!WRFULL && !g_valid) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         err_q <= 1'b0;
      end else if (timeout_hit) begin
         err_q <= 1'b1;
      end else if (ERR_CLR) begin
         err_q <= 1'b0;
      end
   end

   assign TIMEOUT_ERR = err_q;
`else
   localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
   logic unused_err_clr;

   assign unused_err_clr = ERR_CLR;
   assign timeout_hit    = 1'b0;
   assign TIMEOUT_ERR    = 1'b0;
`endif

   always_ff @(posedge CLK or negedge RESETn) begin
      if (!RESETn) begin
         state    <= ST_IDLE;
         grant_q  <= '0;
         last_idx <= IDXW'(NUM_CH - 1);
      end else begin
         case (state)
            ST_IDLE: begin
               if (|CH_VALID) begin
                  grant_q <= win;
                  state   <= ST_XFER;
               end
            end
            ST_XFER: begin
               if (accept_last || timeout_hit) begin
                  grant_q  <= '0;
                  last_idx <= g_idx;
                  state    <= ST_IDLE;
               end
            end
            default: begin
               grant_q <= '0;
               state   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_transport_arbiter.sv
// Directed bench for transport_arbiter with two channels; timeout scenario runs when TRANSPORT_ARB_TIMEOUT_EN is defined.
module tb_transport_arbiter;

   logic        CLK;
   logic        RESETn;
   logic [1:0]  CH_VALID;
   logic [15:0] CH_DATA;
   logic [1:0]  CH_LAST;
   logic [1:0]  CH_READY;
   logic        WREN;
   logic [7:0]  WRDATA;
   logic        WRFULL;
   logic [1:0]  GRANT;
   logic        BUSY;
   logic        TIMEOUT_ERR;
   logic        ERR_CLR;

   int n_chk;
   int n_fail;

   logic [7:0]  sdat  [2][8];
   logic        slast [2][8];
   int          slen  [2];
   int          sptr  [2];
   logic        wf    [64];
   logic [15:0] outq  [$];
   logic [15:0] expq  [$];
   int          ncyc;

   transport_arbiter #(
      .NUM_CH         (2),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .CLK         (CLK),
      .RESETn      (RESETn),
      .CH_VALID    (CH_VALID),
      .CH_DATA     (CH_DATA),
      .CH_LAST     (CH_LAST),
      .CH_READY    (CH_READY),
      .WREN        (WREN),
      .WRDATA      (WRDATA),
      .WRFULL      (WRFULL),
      .GRANT       (GRANT),
      .BUSY        (BUSY),
      .TIMEOUT_ERR (TIMEOUT_ERR),
      .ERR_CLR     (ERR_CLR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_src();
      for (int c = 0; c < 2; c++) begin
         slen[c] = 0;
         sptr[c] = 0;
      end
      for (int k = 0; k < 64; k++) wf[k] = 1'b0;
      outq.delete();
      expq.delete();
   endtask

   task automatic add_byte(input int ch, input logic [7:0] d, input logic l);
      sdat[ch][slen[ch]]  = d;
      slast[ch][slen[ch]] = l;
      slen[ch]++;
      expq.push_back({7'd0, ch[0], d});
   endtask

   // Sources hold valid until their byte is accepted; stalls come from the wf schedule.
   task automatic run_src(input int max_cyc, output int cyc);
      logic [1:0] prev_grant;
      cyc        = 0;
      prev_grant = GRANT;
      while (((sptr[0] < slen[0]) || (sptr[1] < slen[1])) && (cyc < max_cyc)) begin
         for (int c = 0; c < 2; c++) begin
            if (sptr[c] < slen[c]) begin
               CH_VALID[c]       = 1'b1;
               CH_DATA[8*c +: 8] = sdat[c][sptr[c]];
               CH_LAST[c]        = slast[c][sptr[c]];
            end else begin
               CH_VALID[c]       = 1'b0;
               CH_DATA[8*c +: 8] = 8'h00;
               CH_LAST[c]        = 1'b0;
            end
         end
         WRFULL = wf[cyc];
         @(negedge CLK);
         if (WRFULL && BUSY) begin
            chk("stall_ready", {30'd0, CH_READY}, 32'd0);
            chk("stall_wren", {31'd0, WREN}, 32'd0);
            chk("stall_grant", {30'd0, GRANT}, {30'd0, prev_grant});
         end
         if (WREN) outq.push_back({7'd0, GRANT[1], WRDATA});
         for (int c = 0; c < 2; c++) begin
            if (CH_VALID[c] && CH_READY[c]) sptr[c]++;
         end
         prev_grant = GRANT;
         tick();
         cyc++;
      end
      chk("src_budget", {31'd0, (cyc < max_cyc)}, 32'd1);
      CH_VALID = 2'b00;
      CH_LAST  = 2'b00;
      CH_DATA  = 16'h0000;
      WRFULL   = 1'b0;
   endtask

   task automatic compare_out(input string name);
      chk({name, "_len"}, outq.size(), expq.size());
      for (int i = 0; i < outq.size() && i < expq.size(); i++)
         chk($sformatf("%s_b%0d", name, i), {16'd0, outq[i]}, {16'd0, expq[i]});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_chk    = 0;
      n_fail   = 0;
      RESETn   = 1'b0;
      CH_VALID = 2'b00;
      CH_DATA  = 16'h0000;
      CH_LAST  = 2'b00;
      WRFULL   = 1'b0;
      ERR_CLR  = 1'b0;
      repeat (3) @(posedge CLK);
      #2;
      chk("rst_grant", {30'd0, GRANT}, 32'd0);
      chk("rst_busy", {31'd0, BUSY}, 32'd0);
      chk("rst_wren", {31'd0, WREN}, 32'd0);
      chk("rst_wrdata", {24'd0, WRDATA}, 32'd0);
      chk("rst_ready", {30'd0, CH_READY}, 32'd0);
      chk("rst_terr", {31'd0, TIMEOUT_ERR}, 32'd0);
      @(negedge CLK);
      RESETn = 1'b1;
      tick();

      // Three-byte packet on ch0.
      CH_VALID = 2'b01; CH_DATA = 16'h00A1; CH_LAST = 2'b00;
      #1;
      chk("t1_idle_ready", {30'd0, CH_READY}, 32'd0);
      chk("t1_idle_wren", {31'd0, WREN}, 32'd0);
      tick();
      #1;
      chk("t1_grant", {30'd0, GRANT}, 32'd1);
      chk("t1_busy", {31'd0, BUSY}, 32'd1);
      chk("t1_wren_a1", {31'd0, WREN}, 32'd1);
      chk("t1_data_a1", {24'd0, WRDATA}, 32'hA1);
      tick();
      CH_DATA = 16'h00A2;
      #1;
      chk("t1_wren_a2", {31'd0, WREN}, 32'd1);
      chk("t1_data_a2", {24'd0, WRDATA}, 32'hA2);
      tick();
      CH_DATA = 16'h00A3; CH_LAST = 2'b01;
      #1;
      chk("t1_wren_a3", {31'd0, WREN}, 32'd1);
      chk("t1_data_a3", {24'd0, WRDATA}, 32'hA3);
      tick();
      CH_VALID = 2'b00; CH_LAST = 2'b00; CH_DATA = 16'h0000;
      #1;
      chk("t1_busy_end", {31'd0, BUSY}, 32'd0);
      chk("t1_grant_end", {30'd0, GRANT}, 32'd0);
      chk("t1_wren_end", {31'd0, WREN}, 32'd0);

      // Reset asserted mid-packet on ch1.
      CH_VALID = 2'b10; CH_DATA = 16'h6100; CH_LAST = 2'b00;
      tick();
      #1;
      chk("rs_grant", {30'd0, GRANT}, 32'd2);
      chk("rs_data61", {24'd0, WRDATA}, 32'h61);
      tick();
      CH_DATA = 16'h6200;
      #1;
      chk("rs_wren62", {31'd0, WREN}, 32'd1);
      RESETn = 1'b0;
      #1;
      chk("rs_async_wren", {31'd0, WREN}, 32'd0);
      chk("rs_async_grant", {30'd0, GRANT}, 32'd0);
      chk("rs_async_ready", {30'd0, CH_READY}, 32'd0);
      chk("rs_async_busy", {31'd0, BUSY}, 32'd0);
      chk("rs_async_wrdata", {24'd0, WRDATA}, 32'd0);
      CH_VALID = 2'b00; CH_DATA = 16'h0000;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RESETn = 1'b1;
      tick();

      // Both channels back-to-back with 2-byte packets; ch0 must win first after reset.
      clear_src();
      add_byte(0, 8'h01, 1'b0); add_byte(0, 8'h02, 1'b1);
      add_byte(1, 8'h11, 1'b0); add_byte(1, 8'h12, 1'b1);
      add_byte(0, 8'h03, 1'b0); add_byte(0, 8'h04, 1'b1);
      add_byte(1, 8'h13, 1'b0); add_byte(1, 8'h14, 1'b1);
      // Expected order interleaves per packet, not per channel push order.
      expq.delete();
      expq.push_back(16'h0001); expq.push_back(16'h0002);
      expq.push_back(16'h0111); expq.push_back(16'h0112);
      expq.push_back(16'h0003); expq.push_back(16'h0004);
      expq.push_back(16'h0113); expq.push_back(16'h0114);
      run_src(50, ncyc);
      compare_out("rr");
      chk("rr_cycles", ncyc, 32'd12);

      // Five-cycle FIFO-full stall inside a ch0 packet, ch1 waiting.
      clear_src();
      add_byte(0, 8'h21, 1'b0); add_byte(0, 8'h22, 1'b0);
      add_byte(0, 8'h23, 1'b0); add_byte(0, 8'h24, 1'b1);
      add_byte(1, 8'h31, 1'b1);
      for (int k = 3; k < 8; k++) wf[k] = 1'b1;
      run_src(50, ncyc);
      compare_out("stall");
      chk("stall_cycles", ncyc, 32'd12);

`ifdef TRANSPORT_ARB_TIMEOUT_EN
      // ch0 sends one byte then goes silent; 16 empty cycles abort the grant.
      CH_VALID = 2'b11; CH_DATA = 16'h5141; CH_LAST = 2'b10;
      tick();
      #1;
      chk("to_grant0", {30'd0, GRANT}, 32'd1);
      chk("to_data41", {24'd0, WRDATA}, 32'h41);
      tick();
      CH_VALID = 2'b10;
      #1;
      chk("to_busy_c2", {31'd0, BUSY}, 32'd1);
      repeat (15) tick();
      #1;
      chk("to_busy_c17", {31'd0, BUSY}, 32'd1);
      chk("to_err_c17", {31'd0, TIMEOUT_ERR}, 32'd0);
      tick();
      #1;
      chk("to_busy_c18", {31'd0, BUSY}, 32'd0);
      chk("to_grant_c18", {30'd0, GRANT}, 32'd0);
      chk("to_err_set", {31'd0, TIMEOUT_ERR}, 32'd1);
      tick();
      #1;
      chk("to_grant1", {30'd0, GRANT}, 32'd2);
      chk("to_data51", {24'd0, WRDATA}, 32'h51);
      chk("to_err_sticky", {31'd0, TIMEOUT_ERR}, 32'd1);
      ERR_CLR = 1'b1;
      tick();
      ERR_CLR = 1'b0; CH_VALID = 2'b00; CH_LAST = 2'b00; CH_DATA = 16'h0000;
      #1;
      chk("to_err_clr", {31'd0, TIMEOUT_ERR}, 32'd0);
      chk("to_busy_end", {31'd0, BUSY}, 32'd0);
`else
      // Without the timeout the grant is held through a long source gap.
      CH_VALID = 2'b01; CH_DATA = 16'h0081; CH_LAST = 2'b00;
      tick();
      #1;
      chk("hold_data81", {24'd0, WRDATA}, 32'h81);
      tick();
      CH_VALID = 2'b10; ERR_CLR = 1'b1;
      repeat (40) tick();
      #1;
      chk("hold_busy", {31'd0, BUSY}, 32'd1);
      chk("hold_grant", {30'd0, GRANT}, 32'd1);
      chk("hold_ready1", {30'd0, CH_READY}, 32'd1);
      chk("hold_terr", {31'd0, TIMEOUT_ERR}, 32'd0);
      ERR_CLR = 1'b0;
      CH_VALID = 2'b11; CH_DATA = 16'h0082; CH_LAST = 2'b01;
      #1;
      chk("hold_data82", {24'd0, WRDATA}, 32'h82);
      chk("hold_wren82", {31'd0, WREN}, 32'd1);
      tick();
      CH_VALID = 2'b00; CH_LAST = 2'b00; CH_DATA = 16'h0000;
      #1;
      chk("hold_busy_end", {31'd0, BUSY}, 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/transport_arbiter.md
TRANSPORT_ARBITER -- requirements
Module: transport_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of byte-stream requesters (legal range 2..4).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, cycles a granted channel may hold a grant without valid data (used only with TRANSPORT_ARB_TIMEOUT_EN).
REQ-003 SHALL have port CLK  input  1  single clock for all logic.
REQ-004 SHALL have port RESETn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port CH_VALID  input  NUM_CH  per-channel byte valid.
REQ-006 SHALL have port CH_DATA  input  8*NUM_CH  per-channel byte; channel i occupies bits [8i+7:8i].
REQ-007 SHALL have port CH_LAST  input  NUM_CH  marks the final byte of a packet.
REQ-008 SHALL have port CH_READY  output  NUM_CH  byte accepted when valid and ready are both high.
REQ-009 SHALL have port WREN  output  1  TX FIFO write enable.
REQ-010 SHALL have port WRDATA  output  8  TX FIFO write data.
REQ-011 SHALL have port WRFULL  input  1  TX FIFO full.
REQ-012 SHALL have port GRANT  output  NUM_CH  one-hot current owner; all zero when idle.
REQ-013 SHALL have port BUSY  output  1  high while in XFER.
REQ-014 SHALL have port TIMEOUT_ERR  output  1  sticky stall-abort flag.
REQ-015 SHALL have port ERR_CLR  input  1  clears TIMEOUT_ERR.

Function
REQ-016 SHALL implement an FSM with states IDLE and XFER.
REQ-017 In IDLE with any CH_VALID high, SHALL register the round-robin winner into GRANT and enter XFER on the next edge. The winner is the first valid channel after the last granted channel, wrapping NUM_CH-1 to 0.
REQ-018 In IDLE, CH_READY and WREN SHALL be 0.
REQ-019 In XFER, CH_READY[g] SHALL equal GRANT[g] & ~WRFULL (combinational); all other CH_READY bits SHALL be 0.
REQ-020 WREN SHALL equal CH_VALID[g] & CH_READY[g], and WRDATA SHALL equal the granted channel's CH_DATA, with zero latency.
REQ-021 When a byte with CH_LAST=1 is accepted, SHALL return to IDLE, store g as last-granted, and clear GRANT.
REQ-022 Packets SHALL never interleave. The grant is held across WRFULL stalls and source gaps until LAST or a timeout.
REQ-023 Requests arriving while in XFER SHALL wait. Simultaneous requests in IDLE SHALL be resolved only by the round-robin pointer.
REQ-024 A single-byte packet SHALL occupy exactly 2 cycles: one IDLE arbitration cycle and one XFER cycle.

Reset
REQ-025 Asserting RESETn low SHALL asynchronously force state IDLE, GRANT=0, last-granted=NUM_CH-1 (so channel 0 wins first), the timeout counter to 0, and TIMEOUT_ERR=0.
REQ-026 During reset, CH_READY=0, WREN=0, WRDATA=0 and BUSY=0. A packet in flight at reset SHALL be dropped with no partial resumption.

Configuration
REQ-027 With macro TRANSPORT_ARB_TIMEOUT_EN defined:
- In XFER, a counter SHALL increment on each cycle with CH_VALID[g]=0 and reset to 0 on each accepted byte.
- WRFULL stall cycles SHALL hold the counter unchanged.
- When the counter reaches TIMEOUT_CYCLES, the FSM SHALL return to IDLE, update last-granted and set TIMEOUT_ERR.
- TIMEOUT_ERR SHALL clear on ERR_CLR=1. Set SHALL win over a simultaneous clear.
REQ-028 Without TRANSPORT_ARB_TIMEOUT_EN, no counter SHALL exist, TIMEOUT_ERR SHALL be tied 0, ERR_CLR SHALL be ignored, and the grant SHALL be held indefinitely.

Structure
REQ-029 Package transport_arb_pkg SHALL hold the FSM state enum, the byte_t typedef (8-bit), and the default TIMEOUT_CYCLES constant.
REQ-030 Round-robin selection SHALL be a sub-module rr_arbiter: inputs request vector and last-grant index; output one-hot winner. It SHALL be purely combinational.

Verification
REQ-031 Reset, then CH_VALID=01 with a 3-byte packet 0xA1,0xA2,0xA3(LAST) -> GRANT=01 after 1 cycle; WREN on 3 consecutive cycles with WRDATA A1,A2,A3; BUSY falls after A3.
REQ-032 Both channels valid continuously with 2-byte packets -> grant order ch0,ch1,ch0,ch1; no byte from ch1 between ch0 bytes.
REQ-033 WRFULL=1 for 5 cycles mid-packet -> CH_READY=0 and WREN=0 for those 5 cycles; GRANT unchanged; no byte lost or duplicated.
REQ-034 With TRANSPORT_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, ch0 sends 1 byte then drops valid -> IDLE after 16 cycles; TIMEOUT_ERR=1; ch1 granted next; ERR_CLR clears the flag.
REQ-035 RESETn pulsed low mid-packet -> WREN=0 and GRANT=0 immediately (asynchronously); first grant after release goes to ch0.
